// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch-operand and HI/LO busy interlocks,
// taken-branch squash of F/D, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MD_LAT     = 4,
    parameter bit DELAY_SLOT = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_is_branch,
    input  logic             br_taken,
    input  logic             d_is_muldiv,
    input  logic             d_rd_hilo,
    input  logic             e_regwrite,
    input  logic             e_memread,
    input  logic [4:0]       e_wreg,
    input  logic             m_memread,
    input  logic [4:0]       m_wreg,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             dbg_md_state
);

    localparam int MW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [MW-1:0] MD_LOAD = MW'(MD_LAT - 1);

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    md_state_t     state, state_nx;
    logic [MW-1:0] cnt, cnt_nx;

    logic match_e, match_m;
    logic load_use, br_haz, md_haz, stall;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    always_comb begin
        match_e = (e_wreg != 5'd0) &&
                  ((d_use_rs && d_rs == e_wreg) || (d_use_rt && d_rt == e_wreg));
        match_m = (m_wreg != 5'd0) &&
                  ((d_use_rs && d_rs == m_wreg) || (d_use_rt && d_rt == m_wreg));
    end

    assign load_use = e_memread && e_regwrite && match_e;
    assign br_haz   = d_is_branch && ((e_regwrite && match_e) || (m_memread && match_m));
    assign md_haz   = md_busy && (d_is_muldiv || d_rd_hilo);
    assign stall    = load_use | br_haz | md_haz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            MD_IDLE: begin
                if (d_is_muldiv && !stall) begin
                    state_nx = MD_BUSY;
                    cnt_nx   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_nx = MD_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = MD_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign md_busy      = (state == MD_BUSY);
    assign dbg_md_state = (state == MD_BUSY);

    // Stall wins over flush: a held branch must not squash its own successor.
    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b1;
        if (reset && !stall) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            de_flush = 1'b0;
            fd_flush = br_taken && d_is_branch && !DELAY_SLOT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against three differently-parameterised instances.
module tb_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wreg, m_wreg;
    logic       d_use_rs, d_use_rt, d_is_branch, br_taken, d_is_muldiv, d_rd_hilo;
    logic       e_regwrite, e_memread, m_memread;

    logic        pc_en, fd_en, fd_flush, de_flush, md_busy, dbg_md_state;
    logic [15:0] stall_cnt;
    logic        ds_pc_en, ds_fd_en, ds_fd_flush, ds_de_flush, ds_md_busy, ds_dbg;
    logic [15:0] ds_stall_cnt;
    logic        st_pc_en, st_fd_en, st_fd_flush, st_de_flush, st_md_busy, st_dbg;
    logic [2:0]  st_stall_cnt;

    typedef struct packed {
        logic        pc_en;
        logic        fd_en;
        logic        fd_flush;
        logic        de_flush;
        logic        md_busy;
        logic [15:0] cnt;
        logic        ds_fd_flush;
        logic [2:0]  sat_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(1'b0), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs),
        .d_use_rt(d_use_rt), .d_is_branch(d_is_branch), .br_taken(br_taken),
        .d_is_muldiv(d_is_muldiv), .d_rd_hilo(d_rd_hilo), .e_regwrite(e_regwrite),
        .e_memread(e_memread), .e_wreg(e_wreg), .m_memread(m_memread), .m_wreg(m_wreg),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .dbg_md_state(dbg_md_state));

    hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(1'b1), .CNT_W(16)) u_ds1 (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs),
        .d_use_rt(d_use_rt), .d_is_branch(d_is_branch), .br_taken(br_taken),
        .d_is_muldiv(d_is_muldiv), .d_rd_hilo(d_rd_hilo), .e_regwrite(e_regwrite),
        .e_memread(e_memread), .e_wreg(e_wreg), .m_memread(m_memread), .m_wreg(m_wreg),
        .pc_en(ds_pc_en), .fd_en(ds_fd_en), .fd_flush(ds_fd_flush), .de_flush(ds_de_flush),
        .md_busy(ds_md_busy), .stall_cnt(ds_stall_cnt), .dbg_md_state(ds_dbg));

    hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(1'b0), .CNT_W(3)) u_sat (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs),
        .d_use_rt(d_use_rt), .d_is_branch(d_is_branch), .br_taken(br_taken),
        .d_is_muldiv(d_is_muldiv), .d_rd_hilo(d_rd_hilo), .e_regwrite(e_regwrite),
        .e_memread(e_memread), .e_wreg(e_wreg), .m_memread(m_memread), .m_wreg(m_wreg),
        .pc_en(st_pc_en), .fd_en(st_fd_en), .fd_flush(st_fd_flush), .de_flush(st_de_flush),
        .md_busy(st_md_busy), .stall_cnt(st_stall_cnt), .dbg_md_state(st_dbg));

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d pending, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clear_in();
        d_rs = 5'd0; d_rt = 5'd0; e_wreg = 5'd0; m_wreg = 5'd0;
        d_use_rs = 1'b0; d_use_rt = 1'b0; d_is_branch = 1'b0; br_taken = 1'b0;
        d_is_muldiv = 1'b0; d_rd_hilo = 1'b0; e_regwrite = 1'b0; e_memread = 1'b0;
        m_memread = 1'b0;
    endtask

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic expect_cyc(input logic pc, input logic fd, input logic fdf, input logic def,
                              input logic busy, input int cnt, input logic ds_fdf);
        exp_t e;
        e.pc_en       = pc;
        e.fd_en       = fd;
        e.fd_flush    = fdf;
        e.de_flush    = def;
        e.md_busy     = busy;
        e.cnt         = 16'(cnt);
        e.ds_fd_flush = ds_fdf;
        e.sat_cnt     = (cnt > 7) ? 3'd7 : 3'(cnt);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // scoreboard monitor
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_en",        int'(pc_en),        int'(e.pc_en));
            chk("fd_en",        int'(fd_en),        int'(e.fd_en));
            chk("fd_flush",     int'(fd_flush),     int'(e.fd_flush));
            chk("de_flush",     int'(de_flush),     int'(e.de_flush));
            chk("md_busy",      int'(md_busy),      int'(e.md_busy));
            chk("dbg_md_state", int'(dbg_md_state), int'(e.md_busy));
            chk("stall_cnt",    int'(stall_cnt),    int'(e.cnt));
            chk("ds1_fd_flush", int'(ds_fd_flush),  int'(e.ds_fd_flush));
            chk("ds1_pc_en",    int'(ds_pc_en),     int'(e.pc_en));
            chk("sat_stall_cnt", int'(st_stall_cnt), int'(e.sat_cnt));
        end
    end

    // stimulus: expect_cyc(pc_en, fd_en, fd_flush, de_flush, md_busy, stall_cnt, ds1_fd_flush)
    initial begin
        clear_in();
        reset = 1'b0;
        @(posedge clock); #1;
        // in reset a taken branch must still not flush F/D
        d_is_branch = 1'b1; br_taken = 1'b1;
        expect_cyc(0, 0, 0, 1, 0, 0, 0);
        clear_in();
        reset = 1'b1;

        // load-use on rs, then the load leaves E
        e_memread = 1'b1; e_regwrite = 1'b1; e_wreg = 5'd8; d_use_rs = 1'b1; d_rs = 5'd8;
        expect_cyc(0, 0, 0, 1, 0, 0, 0);
        e_memread = 1'b0;
        expect_cyc(1, 1, 0, 0, 0, 1, 0);

        // register 0 never matches; unused rt never matches; used rt does
        e_memread = 1'b1; e_wreg = 5'd0; d_rs = 5'd0;
        expect_cyc(1, 1, 0, 0, 0, 1, 0);
        e_wreg = 5'd9; d_use_rs = 1'b0; d_rt = 5'd9; d_use_rt = 1'b0;
        expect_cyc(1, 1, 0, 0, 0, 1, 0);
        d_use_rt = 1'b1;
        expect_cyc(0, 0, 0, 1, 0, 1, 0);

        // taken branch without hazard, then not a branch
        clear_in();
        d_is_branch = 1'b1; br_taken = 1'b1;
        expect_cyc(1, 1, 1, 0, 0, 2, 0);
        d_is_branch = 1'b0;
        expect_cyc(1, 1, 0, 0, 0, 2, 0);

        // branch operand produced in E, then a load in M, then resolved
        d_is_branch = 1'b1; br_taken = 1'b1; d_use_rs = 1'b1; d_rs = 5'd5;
        e_regwrite = 1'b1; e_wreg = 5'd5;
        expect_cyc(0, 0, 0, 1, 0, 2, 0);
        e_regwrite = 1'b0; m_memread = 1'b1; m_wreg = 5'd5;
        expect_cyc(0, 0, 0, 1, 0, 3, 0);
        m_memread = 1'b0;
        expect_cyc(1, 1, 1, 0, 0, 4, 0);

        // non-branch with ALU producer in E and load in M: forwarded, no stall
        d_is_branch = 1'b0; br_taken = 1'b0; e_regwrite = 1'b1; e_wreg = 5'd5;
        m_memread = 1'b1; m_wreg = 5'd5;
        expect_cyc(1, 1, 0, 0, 0, 4, 0);

        // mult issue at T0, mfhi in D from T1 stalls T1..T4
        clear_in();
        d_is_muldiv = 1'b1;
        expect_cyc(1, 1, 0, 0, 0, 4, 0);
        d_is_muldiv = 1'b0; d_rd_hilo = 1'b1;
        expect_cyc(0, 0, 0, 1, 1, 4, 0);
        expect_cyc(0, 0, 0, 1, 1, 5, 0);
        expect_cyc(0, 0, 0, 1, 1, 6, 0);
        expect_cyc(0, 0, 0, 1, 1, 7, 0);
        expect_cyc(1, 1, 0, 0, 0, 8, 0);

        // second issue, then reset asserted mid-BUSY
        d_rd_hilo = 1'b0; d_is_muldiv = 1'b1;
        expect_cyc(1, 1, 0, 0, 0, 8, 0);
        d_is_muldiv = 1'b0; d_rd_hilo = 1'b1;
        expect_cyc(0, 0, 0, 1, 1, 8, 0);
        expect_cyc(0, 0, 0, 1, 1, 9, 0);
        reset = 1'b0;
        expect_cyc(0, 0, 0, 1, 0, 0, 0);

        // after release a mult issues unstalled; a second mult while busy is held
        reset = 1'b1;
        d_rd_hilo = 1'b0; d_is_muldiv = 1'b1;
        expect_cyc(1, 1, 0, 0, 0, 0, 0);
        d_is_muldiv = 1'b0;
        expect_cyc(1, 1, 0, 0, 1, 0, 0);
        d_is_muldiv = 1'b1;
        expect_cyc(0, 0, 0, 1, 1, 0, 0);
        clear_in();

        @(posedge clock); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
